packet_ingress: RTL and testbench

PACKET_INGRESS -- requirements
Module: packet_ingress

---
 rtl/my_interface.sv | 26 ++
 rtl/ingress_skid.sv | 74 +++++++
 rtl/packet_ingress.sv | 191 +++++++++++++++++++
 tb/tb_packet_ingress.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_interface.sv
// +----------------------------------------------------------------------------+
// | my_interface                                                               |
// | Shared widths, header magic and FSM state type for packet_ingress.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package my_interface;

  localparam int phit_size    = 512;
  localparam int dwidth_RFadd = 8;

  localparam logic [15:0] c_ingress_magic = 16'hAC15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_HS_REQ = 3'd2,
    S_HS_REL = 3'd3,
    S_STREAM = 3'd4,
    S_DRAIN  = 3'd5
  } ingress_state_e;

endpackage

`default_nettype wire

// File: rtl/ingress_skid.sv
// +----------------------------------------------------------------------------+
// | ingress_skid                                                               |
// | Two-entry valid/ready skid buffer; registered in_ready, full throughput.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ingress_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         w_push;
  logic         w_pop;

  assign in_ready  = ~skid_vld_q;
  assign out_data  = main_q;
  assign out_valid = main_vld_q;
  assign w_push    = in_valid & ~skid_vld_q;
  assign w_pop     = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      // input is blocked while the skid entry is occupied
      if (w_pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (w_push) begin
      if (!main_vld_q || w_pop) begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end else if (w_pop) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_ingress.sv
// +----------------------------------------------------------------------------+
// | packet_ingress                                                             |
// | Header parse, table load, stream handshake and payload forwarding.         |
// | Optional macro ACIS_INGRESS_MAGIC_CHK_EN enables header magic checking.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module packet_ingress
  import my_interface::*;
#(
  parameter int PHIT_W = phit_size,
  parameter int ADDW   = dwidth_RFadd
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PHIT_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [PHIT_W-1:0] wr_data,
  output logic              start_loader,
  output logic [ADDW-1:0]   num_entry_config_table,
  output logic [ADDW-1:0]   num_entry_inbound,
  output logic              start_stream_in,
  input  logic              ready_stream_in,
  output logic [PHIT_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic              err
);

  ingress_state_e    state_q, state_d;
  logic [ADDW:0]     cnt_q, cnt_d;
  logic [ADDW:0]     len_q, len_d;
  logic [ADDW-1:0]   cfg_q, cfg_d;
  logic [ADDW-1:0]   inb_q, inb_d;
  logic [PHIT_W-1:0] wr_data_q, wr_data_d;
  logic              start_loader_q, start_loader_d;
  logic              err_q, err_d;

  logic [ADDW-1:0]   w_hdr_cfg;
  logic [ADDW-1:0]   w_hdr_inb;
  logic [ADDW:0]     w_hdr_len;
  logic [ADDW:0]     w_cnt_inc;
  logic              w_magic_ok;
  logic              w_ready;
  logic              w_skid_in_valid;
  logic              w_skid_in_ready;
  logic [PHIT_W:0]   w_skid_out;

  assign w_hdr_cfg = s_tdata[ADDW-1:0];
  assign w_hdr_inb = s_tdata[2*ADDW-1:ADDW];
  assign w_hdr_len = {1'b0, w_hdr_cfg} + {1'b0, w_hdr_inb};
  assign w_cnt_inc = cnt_q + (ADDW+1)'(1);

`ifdef ACIS_INGRESS_MAGIC_CHK_EN
  assign w_magic_ok = (s_tdata[63:48] == c_ingress_magic);
`else
  assign w_magic_ok = 1'b1;
`endif

  always_comb begin
    w_ready = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD, S_DRAIN: w_ready = 1'b1;
      S_STREAM:                w_ready = w_skid_in_ready;
      default:                 w_ready = 1'b0;
    endcase
  end

  assign s_tready        = rst & w_ready;
  assign start_stream_in = (state_q == S_HS_REQ);
  assign busy            = (state_q != S_IDLE);
  assign w_skid_in_valid = s_tvalid & (state_q == S_STREAM);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    cfg_d          = cfg_q;
    inb_d          = inb_q;
    wr_data_d      = wr_data_q;
    start_loader_d = 1'b0;
    err_d          = err_q;
    case (state_q)
      S_IDLE: begin
        if (s_tvalid) begin
          cfg_d = w_hdr_cfg;
          inb_d = w_hdr_inb;
          len_d = w_hdr_len;
          cnt_d = '0;
          if (s_tlast) begin
            err_d = 1'b1;
          end else if (!w_magic_ok) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else if (w_hdr_len != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_HS_REQ;
          end
        end
      end
      S_LOAD: begin
        // the load must be one unbroken burst inside the packet
        if (!s_tvalid || s_tlast) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          wr_data_d      = s_tdata;
          start_loader_d = (cnt_q == '0);
          cnt_d          = w_cnt_inc;
          if (w_cnt_inc == len_q) begin
            state_d = S_HS_REQ;
          end
        end
      end
      S_HS_REQ: begin
        if (ready_stream_in) begin
          state_d = S_HS_REL;
        end
      end
      S_HS_REL: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (s_tvalid && w_skid_in_ready && s_tlast) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (s_tvalid && s_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      cfg_q          <= '0;
      inb_q          <= '0;
      wr_data_q      <= '0;
      start_loader_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      cfg_q          <= cfg_d;
      inb_q          <= inb_d;
      wr_data_q      <= wr_data_d;
      start_loader_q <= start_loader_d;
      err_q          <= err_d;
    end
  end

  assign wr_data                = wr_data_q;
  assign start_loader           = start_loader_q;
  assign num_entry_config_table = cfg_q;
  assign num_entry_inbound      = inb_q;
  assign err                    = err_q;

  ingress_skid #(
    .W (PHIT_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_tlast, s_tdata}),
    .in_valid  (w_skid_in_valid),
    .in_ready  (w_skid_in_ready),
    .out_data  (w_skid_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign m_tdata = w_skid_out[PHIT_W-1:0];
  assign m_tlast = w_skid_out[PHIT_W];

endmodule

`default_nettype wire

// File: tb/tb_packet_ingress.sv
// +----------------------------------------------------------------------------+
// | tb_packet_ingress                                                          |
// | Randomised packet traffic against a transaction-level expectation model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_packet_ingress;

  localparam int PW = 512;
  localparam int AW = 8;

  typedef logic [PW-1:0] word_t;

  logic          clk;
  logic          rst;
  logic [PW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [PW-1:0] wr_data;
  logic          start_loader;
  logic [AW-1:0] num_entry_config_table;
  logic [AW-1:0] num_entry_inbound;
  logic          start_stream_in;
  logic          ready_stream_in;
  logic [PW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic          err;

  int    n_vec;
  int    n_err;
  word_t exp_pay[$];

  packet_ingress #(
    .PHIT_W (PW),
    .ADDW   (AW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_tdata                (s_tdata),
    .s_tvalid               (s_tvalid),
    .s_tlast                (s_tlast),
    .s_tready               (s_tready),
    .wr_data                (wr_data),
    .start_loader           (start_loader),
    .num_entry_config_table (num_entry_config_table),
    .num_entry_inbound      (num_entry_inbound),
    .start_stream_in        (start_stream_in),
    .ready_stream_in        (ready_stream_in),
    .m_tdata                (m_tdata),
    .m_tvalid               (m_tvalid),
    .m_tlast                (m_tlast),
    .m_tready               (m_tready),
    .busy                   (busy),
    .err                    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t rand_phit();
    word_t v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic word_t make_hdr(input int cfg, input int inb);
    word_t h;
    h        = rand_phit();
    h[7:0]   = 8'(cfg);
    h[15:8]  = 8'(inb);
    h[63:48] = 16'hAC15;
`ifndef ACIS_INGRESS_MAGIC_CHK_EN
    // without the checker a corrupt magic must not matter
    if ($urandom_range(0, 3) == 0) h[63:48] = 16'hAC15 ^ 16'($urandom_range(1, 255));
`endif
    return h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    s_tvalid        = 1'b0;
    s_tlast         = 1'b0;
    s_tdata         = '0;
    ready_stream_in = 1'b0;
    m_tready        = 1'b0;
    @(negedge clk);
    chk("rst_s_tready", word_t'(s_tready), word_t'(0));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", word_t'(busy), word_t'(0));
    chk("rst_err", word_t'(err), word_t'(0));
    chk("rst_wr_data", wr_data, word_t'(0));
    chk("rst_start_loader", word_t'(start_loader), word_t'(0));
    chk("rst_cnt_cfg", word_t'(num_entry_config_table), word_t'(0));
    chk("rst_cnt_inb", word_t'(num_entry_inbound), word_t'(0));
    chk("rst_start_stream", word_t'(start_stream_in), word_t'(0));
    chk("rst_m_tvalid", word_t'(m_tvalid), word_t'(0));
    chk("rst_m_tdata", m_tdata, word_t'(0));
    step();
  endtask

  // mode: 0 sink always ready, 1 sink toggles 1/0, 2 sink random
  task automatic run_packet(input int cfg, input int inb, input int npay,
                            input int hs_delay, input int mode, input int gaps);
    word_t ld[$];
    int    len;
    len = cfg + inb;
    s_tdata  = make_hdr(cfg, inb);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("hdr_s_tready", word_t'(s_tready), word_t'(1));
    chk("hdr_busy", word_t'(busy), word_t'(0));
    step();
    for (int i = 0; i < len; i++) begin
      ld.push_back(rand_phit());
      s_tdata = ld[i];
      @(negedge clk);
      if (i == 0) begin
        chk("cnt_cfg", word_t'(num_entry_config_table), word_t'(cfg));
        chk("cnt_inb", word_t'(num_entry_inbound), word_t'(inb));
        chk("busy_load", word_t'(busy), word_t'(1));
        chk("no_early_loader", word_t'(start_loader), word_t'(0));
      end else begin
        chk("wr_data", wr_data, ld[i-1]);
        chk("start_loader", word_t'(start_loader), word_t'(i == 1));
      end
      chk("load_s_tready", word_t'(s_tready), word_t'(1));
      step();
    end
    s_tvalid        = 1'b0;
    s_tdata         = '0;
    ready_stream_in = 1'b0;
    for (int k = 0; k < hs_delay; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (len > 0) begin
          chk("wr_data_last", wr_data, ld[len-1]);
          chk("start_loader_last", word_t'(start_loader), word_t'(len == 1));
        end else begin
          chk("cnt_cfg", word_t'(num_entry_config_table), word_t'(cfg));
          chk("cnt_inb", word_t'(num_entry_inbound), word_t'(inb));
          chk("no_loader_empty", word_t'(start_loader), word_t'(0));
        end
      end
      chk("hs_start", word_t'(start_stream_in), word_t'(1));
      chk("hs_s_tready", word_t'(s_tready), word_t'(0));
      chk("hs_m_tvalid", word_t'(m_tvalid), word_t'(0));
      step();
    end
    ready_stream_in = 1'b1;
    @(negedge clk);
    chk("hs_start_ack", word_t'(start_stream_in), word_t'(1));
    step();
    ready_stream_in = 1'b0;
    @(negedge clk);
    chk("hs_release", word_t'(start_stream_in), word_t'(0));
    chk("rel_m_tvalid", word_t'(m_tvalid), word_t'(0));
    step();

    exp_pay.delete();
    for (int i = 0; i < npay; i++) exp_pay.push_back(rand_phit());
    m_tready = 1'b1;
    fork
      begin : src
        for (int i = 0; i < npay; i++) begin
          int  waits;
          bit  acc;
          if (gaps != 0 && $urandom_range(0, 2) == 0) begin
            s_tvalid = 1'b0;
            step();
          end
          s_tdata  = exp_pay[i];
          s_tlast  = (i == npay - 1);
          s_tvalid = 1'b1;
          acc      = 1'b0;
          waits    = 0;
          while (!acc && waits < 100) begin
            @(negedge clk);
            acc = s_tready;
            step();
            if (!acc) waits++;
          end
          if (!acc) begin
            chk("src_timeout", word_t'(0), word_t'(1));
            break;
          end
          if (mode == 0 && gaps == 0) chk("no_bubble", word_t'(waits), word_t'(0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      begin : sink
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < npay && cyc < 400) begin
          @(negedge clk);
          if (m_tvalid && m_tready) begin
            chk("pay_data", m_tdata, exp_pay[got]);
            chk("pay_last", word_t'(m_tlast), word_t'(got == npay - 1));
            got++;
          end
          step();
          cyc++;
          if (mode == 1)      m_tready = ~m_tready;
          else if (mode == 2) m_tready = 1'($urandom_range(0, 1));
          else                m_tready = 1'b1;
        end
        if (got < npay) chk("sink_timeout", word_t'(got), word_t'(npay));
      end
    join
    @(negedge clk);
    chk("end_busy", word_t'(busy), word_t'(0));
    chk("end_err", word_t'(err), word_t'(0));
    step();
  endtask

  task automatic gap_test();
    word_t d1;
    s_tdata  = make_hdr(3, 2);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      d1      = rand_phit();
      s_tdata = d1;
      step();
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("gap_err_before", word_t'(err), word_t'(0));
    chk("gap_wr_data", wr_data, d1);
    step();
    for (int j = 0; j < 3; j++) begin
      s_tdata  = rand_phit();
      s_tvalid = 1'b1;
      s_tlast  = (j == 2);
      @(negedge clk);
      chk("drain_err", word_t'(err), word_t'(1));
      chk("drain_busy", word_t'(busy), word_t'(1));
      chk("drain_s_tready", word_t'(s_tready), word_t'(1));
      chk("drain_wr_data", wr_data, d1);
      chk("drain_start_stream", word_t'(start_stream_in), word_t'(0));
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("drain_done_busy", word_t'(busy), word_t'(0));
    chk("drain_done_err", word_t'(err), word_t'(1));
    chk("drain_no_loader", word_t'(start_loader), word_t'(0));
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    do_reset();

    run_packet(3, 2, 8, 10, 1, 0);
    run_packet(0, 0, 3, 1, 0, 0);
    for (int n = 0; n < 20; n++) begin
      run_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 8),
                 $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 1));
    end

    gap_test();
    do_reset();

    // reset landing in the middle of a load
    s_tdata  = make_hdr(3, 2);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      s_tdata = rand_phit();
      step();
    end
    do_reset();
    run_packet(1, 0, 2, 2, 2, 1);

    // reset landing in the middle of the stream handshake
    s_tdata  = make_hdr(0, 0);
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_hs_start", word_t'(start_stream_in), word_t'(1));
    step();
    do_reset();

    // header carrying s_tlast
    s_tdata  = make_hdr(2, 1);
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("tlast_hdr_err", word_t'(err), word_t'(1));
    chk("tlast_hdr_busy", word_t'(busy), word_t'(0));
    chk("tlast_hdr_loader", word_t'(start_loader), word_t'(0));
    step();
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
